// File: rtl/neuron_accumulator.sv
// Dot-product accumulator: loads a bias, sums NumInputs signed products, reports the sum and its sign.
// Build option NEURON_ACC_SATURATE_EN: clamp each add to the signed AccWidth range and flag overflow.
//
// state | meaning
// IDLE  | waiting for start; valid_in/product ignored
// ACCUM | adding each qualified product into the accumulator
// DONE  | one-cycle result strobe; sum/is_cat/overflow just updated
module neuron_accumulator #(
  parameter int PixelWidth  = 8,
  parameter int WeightWidth = 5,
  parameter int NumInputs   = 4096,
  parameter int AccWidth    = 32,
  localparam int ProdWidth  = 2 * (WeightWidth + PixelWidth) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [AccWidth-1:0] bias,
  input  logic                       valid_in,
  input  logic signed [ProdWidth-1:0] product,
  output logic                       busy,
  output logic                       done,
  output logic signed [AccWidth-1:0] sum,
  output logic                       is_cat,
  output logic                       overflow
);

  localparam int CntWidth = $clog2(NumInputs);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumInputs - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  ovf_int_q, ovf_int_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AccWidth-1:0]   sum_q, sum_d;
  logic                  is_cat_q, is_cat_d;
  logic                  overflow_q, overflow_d;

  logic [AccWidth-1:0]   prod_ext;
  logic [AccWidth-1:0]   add_res;
  logic                  add_ovf;

  assign prod_ext = {{(AccWidth - ProdWidth){product[ProdWidth-1]}}, product};

`ifdef NEURON_ACC_SATURATE_EN
  // One guard bit exposes a signed overflow as a mismatch of the top two bits.
  logic [AccWidth:0] ext_sum;
  always_comb begin
    ext_sum = {acc_q[AccWidth-1], acc_q} + {prod_ext[AccWidth-1], prod_ext};
    add_ovf = ext_sum[AccWidth] ^ ext_sum[AccWidth-1];
    if (add_ovf) add_res = ext_sum[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                             : {1'b0, {(AccWidth-1){1'b1}}};
    else         add_res = ext_sum[AccWidth-1:0];
  end
`else
  always_comb begin
    add_res = acc_q + prod_ext;
    add_ovf = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_int_d  = ovf_int_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_d      = sum_q;
    is_cat_d   = is_cat_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = bias;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (valid_in) begin
          acc_d     = add_res;
          ovf_int_d = ovf_int_q | add_ovf;
          if (cnt_q == LastIdx) begin
            // Publish the final add directly so outputs change together with done.
            state_d    = S_DONE;
            done_d     = 1'b1;
            sum_d      = add_res;
            is_cat_d   = ~add_res[AccWidth-1] & (|add_res);
            overflow_d = ovf_int_q | add_ovf;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_int_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      is_cat_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_int_q  <= ovf_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      is_cat_q   <= is_cat_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign is_cat   = is_cat_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized bench for neuron_accumulator: a wide instance and a narrow (saturation-prone) instance
// run the same handshake, each checked against an arithmetic reference of the dot product.
module tb_neuron_accumulator;

  localparam int N    = 4;
  localparam int AW_A = 32;
  localparam int PW_A = 27;
  localparam int AW_B = 8;
  localparam int PW_B = 7;

  logic clk, rst, start, valid_in;
  logic signed [AW_A-1:0] bias_a;
  logic signed [PW_A-1:0] prod_a;
  logic signed [AW_B-1:0] bias_b;
  logic signed [PW_B-1:0] prod_b;
  logic busy_a, done_a, is_cat_a, overflow_a;
  logic busy_b, done_b, is_cat_b, overflow_b;
  logic signed [AW_A-1:0] sum_a;
  logic signed [AW_B-1:0] sum_b;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  longint ba, bb;
  longint pa[N];
  longint pb[N];

  neuron_accumulator #(.PixelWidth(8), .WeightWidth(5), .NumInputs(N), .AccWidth(AW_A)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .bias(bias_a), .valid_in(valid_in), .product(prod_a),
    .busy(busy_a), .done(done_a), .sum(sum_a), .is_cat(is_cat_a), .overflow(overflow_a));

  neuron_accumulator #(.PixelWidth(2), .WeightWidth(1), .NumInputs(N), .AccWidth(AW_B)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .bias(bias_b), .valid_in(valid_in), .product(prod_b),
    .busy(busy_b), .done(done_b), .sum(sum_b), .is_cat(is_cat_b), .overflow(overflow_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint wrap(input longint v, input int aw);
    longint m;
    m = v & ((64'sd1 <<< aw) - 1);
    if (m >= (64'sd1 <<< (aw - 1))) m -= (64'sd1 <<< aw);
    return m;
  endfunction

  // Reference: running sum of bias plus products, clamped or wrapped at each step.
  task automatic model(input longint b, input longint p[N], input int aw,
                       output longint s, output longint ov);
    longint mx, mn;
    mx = (64'sd1 <<< (aw - 1)) - 1;
    mn = -(64'sd1 <<< (aw - 1));
    s  = b;
    ov = 0;
    for (int i = 0; i < N; i++) begin
      s = s + p[i];
`ifdef NEURON_ACC_SATURATE_EN
      if (s > mx) begin s = mx; ov = 1; end
      if (s < mn) begin s = mn; ov = 1; end
`else
      s = wrap(s, aw);
`endif
    end
  endtask

  task automatic run_dot(input string tag, input int gap_min, input int gap_max, input bit poke);
    longint es_a, eo_a, es_b, eo_b;
    int d0a, d0b, gaps;
    model(ba, pa, AW_A, es_a, eo_a);
    model(bb, pb, AW_B, es_b, eo_b);
    // A qualified product in IDLE must be dropped.
    valid_in = 1'b1; prod_a = PW_A'($urandom); prod_b = PW_B'($urandom);
    tick();
    valid_in = 1'b0;
    d0a = done_cnt_a; d0b = done_cnt_b;
    bias_a = AW_A'(ba); bias_b = AW_B'(bb); start = 1'b1;
    tick();
    start = 1'b0;
    bias_a = AW_A'($urandom); bias_b = AW_B'($urandom);
    check({tag, " busy_accum"}, longint'(busy_a), 1);
    for (int i = 0; i < N; i++) begin
      gaps = (gap_max > gap_min) ? int'($urandom_range(gap_max, gap_min)) : gap_min;
      for (int g = 0; g < gaps; g++) begin
        valid_in = 1'b0; start = poke;
        prod_a = PW_A'($urandom); prod_b = PW_B'($urandom);
        tick();
      end
      start = 1'b0; valid_in = 1'b1;
      prod_a = PW_A'(pa[i]); prod_b = PW_B'(pb[i]);
      tick();
    end
    prod_a = PW_A'($urandom); prod_b = PW_B'($urandom);
    check({tag, " done_a"}, longint'(done_a), 1);
    check({tag, " busy_done"}, longint'(busy_a), 1);
    check({tag, " sum_a"}, longint'(sum_a), es_a);
    check({tag, " is_cat_a"}, longint'(is_cat_a), longint'(es_a > 0));
    check({tag, " ovf_a"}, longint'(overflow_a), eo_a);
    check({tag, " done_b"}, longint'(done_b), 1);
    check({tag, " sum_b"}, longint'(sum_b), es_b);
    check({tag, " is_cat_b"}, longint'(is_cat_b), longint'(es_b > 0));
    check({tag, " ovf_b"}, longint'(overflow_b), eo_b);
    tick();
    valid_in = 1'b0;
    check({tag, " done_low"}, longint'(done_a), 0);
    check({tag, " busy_idle"}, longint'(busy_a), 0);
    check({tag, " sum_hold"}, longint'(sum_a), es_a);
    tick();
    check({tag, " done_pulses_a"}, longint'(done_cnt_a - d0a), 1);
    check({tag, " done_pulses_b"}, longint'(done_cnt_b - d0b), 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; valid_in = 1'b0;
    bias_a = '0; bias_b = '0; prod_a = '0; prod_b = '0;
    #12;
    check("rst_busy", longint'(busy_a), 0);
    check("rst_done", longint'(done_a), 0);
    check("rst_sum", longint'(sum_a), 0);
    rst = 1'b1;
    tick();

    // Positive decision, back-to-back products; narrow unit sees four products of 63.
    ba = -10; pa = '{3, 4, 5, 6};
    bb = 0;   pb = '{63, 63, 63, 63};
    run_dot("bias_m10", 0, 0, 1'b0);
    check("b33_sum", longint'(sum_a), 8);
`ifdef NEURON_ACC_SATURATE_EN
    check("b35_sum", longint'(sum_b), 127);
    check("b35_ovf", longint'(overflow_b), 1);
`else
    check("b35_sum", longint'(sum_b), -4);
    check("b35_ovf", longint'(overflow_b), 0);
`endif

    // Negative sum with 2-cycle gaps and start poked during ACCUM.
    ba = 0; pa = '{-1, -2, -3, -4};
    bb = 3; pb = '{-1, 2, -3, 4};
    run_dot("gaps_poke", 2, 2, 1'b1);
    check("b34_sum", longint'(sum_a), -10);

    // Reset after two products must discard the partial sum and clear outputs at once.
    bias_a = 32'sd1000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; prod_a = 27'sd77; tick();
    end
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_busy", longint'(busy_a), 0);
    check("mid_rst_sum", longint'(sum_a), 0);
    check("mid_rst_is_cat", longint'(is_cat_a), 0);
    check("mid_rst_ovf", longint'(overflow_a), 0);
    check("mid_rst_done", longint'(done_a), 0);
    #1 rst = 1'b1;
    tick();
    ba = 1; pa = '{0, 0, 0, 0};
    bb = 1; pb = '{0, 0, 0, 0};
    run_dot("after_rst", 0, 1, 1'b0);
    check("b36_sum", longint'(sum_a), 1);

    // Zero sum is not a positive decision.
    ba = 5; pa = '{-5, 0, 0, 0};
    bb = -64; pb = '{-64, -64, 0, 1};
    run_dot("zero_sum", 0, 0, 1'b0);
    check("b37_is_cat", longint'(is_cat_a), 0);

    // Wide unit pushed past its positive limit.
    ba = 64'sd2147483600; pa = '{40, 40, -1, 5};
    bb = 127; pb = '{1, -1, 1, -1};
    run_dot("wide_edge", 0, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      ba = longint'($signed(AW_A'($urandom)));
      bb = longint'($signed(AW_B'($urandom)));
      for (int i = 0; i < N; i++) begin
        pa[i] = longint'($signed(PW_A'($urandom)));
        pb[i] = longint'($signed(PW_B'($urandom)));
      end
      run_dot("rand", 0, 2, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter PixelWidth, default 8, pixel width before the sign-pad bit.
REQ-002 SHALL have parameter WeightWidth, default 5, signed weight width.
REQ-003 SHALL have parameter NumInputs, default 4096, number of products per dot product (≥2).
REQ-004 SHALL have parameter AccWidth, default 32, accumulator width; it SHALL be ≥ ProdWidth = 2*(WeightWidth+PixelWidth)+1.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, begins a dot product (sampled in IDLE only).
REQ-009 SHALL have port bias, input, signed AccWidth, initial accumulator value, sampled with start.
REQ-010 SHALL have port valid_in, input, 1, product qualifier.
REQ-011 SHALL have port product, input, signed ProdWidth, multiplier-stage result (pixel×weight).
REQ-012 SHALL have port busy, output, 1, high in ACCUM and DONE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when result is valid.
REQ-014 SHALL have port sum, output, signed AccWidth, registered final sum.
REQ-015 SHALL have port is_cat, output, 1, decision: 1 iff final sum > 0.
REQ-016 SHALL have port overflow, output, 1, saturation occurred in the last dot product.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-018 IDLE + start: acc ← bias, count ← 0, overflow_int ← 0; next state ACCUM.
REQ-019 IDLE: valid_in and product SHALL be ignored.
REQ-020 ACCUM + valid_in: acc ← acc + sign-extended product, count ← count+1; cycles without valid_in hold acc and count.
REQ-021 ACCUM: when valid_in is accepted with count = NumInputs-1, next state DONE.
REQ-022 DONE: done=1 for exactly one cycle, sum/is_cat/overflow updated in that cycle; next state IDLE.
REQ-023 Latency: done asserts the cycle after the last accepted product.
REQ-024 sum, is_cat, overflow SHALL hold their values until the next DONE or reset.
REQ-025 start while busy SHALL be ignored; valid_in in DONE SHALL be ignored.
REQ-026 Count width SHALL be clog2(NumInputs); count does not wrap within a dot product.
REQ-027 is_cat SHALL be 0 when sum = 0 and when sum is negative.

Reset
REQ-028 rst low SHALL immediately force state IDLE, acc 0, count 0, busy 0, done 0, sum 0, is_cat 0, overflow 0.
REQ-029 Reset mid-ACCUM SHALL discard the partial sum; a new start is required.

Configuration
REQ-030 Macro NEURON_ACC_SATURATE_EN defined: each add SHALL clamp to the signed AccWidth max/min, and overflow SHALL be set if any clamp occurred.
REQ-031 Macro NEURON_ACC_SATURATE_EN undefined: adds SHALL wrap modulo 2^AccWidth, and overflow SHALL be tied 0.

Verification (NumInputs=4 unless noted)
REQ-032 Reset: assert rst low mid-cycle -> all outputs 0 asynchronously, busy 0.
REQ-033 bias=-10, products 3,4,5,6 back-to-back -> done one cycle after the 4th product, sum=8, is_cat=1, overflow=0.
REQ-034 bias=0, products -1,-2,-3,-4 with 2-cycle valid_in gaps and start pulsed during ACCUM -> sum=-10, is_cat=0, single done pulse.
REQ-035 PixelWidth=2, WeightWidth=1 (ProdWidth=7), AccWidth=8, bias=0, four products of 63 -> with macro: sum=127, overflow=1; without macro: sum=-4, is_cat=0, overflow=0.
REQ-036 rst low after 2 products accepted, then start with bias=1 and products 0,0,0,0 -> sum=1, is_cat=1, and no prior partial sum retained.
REQ-037 bias=5, products -5,0,0,0 -> sum=0, is_cat=0.
